// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV64 subset controller: opcodes,
// ALU operation selects and the controller state enumeration.
package core_ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEMRD  = 3'd3,
        S_MEMWR  = 3'd4,
        S_WB     = 3'd5,
        S_BRANCH = 3'd6,
        S_TRAP   = 3'd7
    } ctrl_state_t;

    // Opcodes that share the EXEC step (everything except beq).
    function automatic logic uses_exec(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_LOAD) || (op == OP_IMM) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath bundle: instruction/status inputs and every
// mux select / write enable the controller drives.
interface multicycle_ctrl_fsm_if;
    logic [6:0] opcode;
    logic       zero;
    logic       memReady;
    logic       halt;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       pcSrc;
    logic       iorD;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       ALUSrc;
    logic [1:0] ALUOp;
    logic       regWrite;
    logic       branch;

    modport master (
        input  opcode, zero, memReady, halt,
        output pcWrite, pcWriteCond, pcSrc, iorD, irWrite, memRead, memWrite,
               memtoReg, ALUSrc, ALUOp, regWrite, branch
    );

    modport slave (
        output opcode, zero, memReady, halt,
        input  pcWrite, pcWriteCond, pcSrc, iorD, irWrite, memRead, memWrite,
               memtoReg, ALUSrc, ALUOp, regWrite, branch
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts request cycles without memReady; flags a timeout on the
// MEM_TIMEOUT-th such cycle (memReady in that cycle still wins).
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic active,
    input  logic ready,
    output logic busy,
    output logic timeout
);

    logic [7:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (active && !ready) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign busy    = (count_reg != 8'd0);
    assign timeout = active && !ready && (count_reg == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle sequencing controller (FETCH/DECODE/EXEC/MEM/WB/BRANCH).
// Build option ILLEGAL_TRAP_EN: unknown opcodes trap and raise illegalInstr.
module multicycle_ctrl_fsm
    import core_ctrl_pkg::*;
#(
    parameter int RET_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_ctrl_fsm_if.master bus,
    output logic                  memErr,
    output logic [2:0]            state,
    output logic [RET_W-1:0]      instrRetired
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                  illegalInstr
`endif
);

    ctrl_state_t      state_reg, state_next;
    logic [6:0]       op_reg;
    logic [RET_W-1:0] retired_reg;
    logic             mem_err_reg;
    logic             req_active, retire, wait_busy, wait_timeout, timer_clear;
    logic             unused_zero;

    // zero only gates the PC load inside the datapath (pcWriteCond path).
    assign unused_zero = bus.zero;

    // Once a fetch request has started (count non-zero), halt is ignored.
    assign req_active = ((state_reg == S_FETCH) && (!bus.halt || wait_busy))
                     || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);

    assign timer_clear = (state_next != state_reg) || wait_timeout;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .active  (req_active),
        .ready   (bus.memReady),
        .busy    (wait_busy),
        .timeout (wait_timeout)
    );

    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        unique case (state_reg)
            S_FETCH: begin
                if (req_active && bus.memReady) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (uses_exec(bus.opcode))          state_next = S_EXEC;
                else if (bus.opcode == OP_BRANCH)   state_next = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
                else                                state_next = S_TRAP;
`else
                else                                state_next = S_FETCH;
`endif
            end
            S_EXEC: begin
                if (op_reg == OP_LOAD)       state_next = S_MEMRD;
                else if (op_reg == OP_STORE) state_next = S_MEMWR;
                else                         state_next = S_WB;
            end
            S_MEMRD: begin
                if (bus.memReady)      state_next = S_WB;
                else if (wait_timeout) state_next = S_FETCH;
            end
            S_MEMWR: begin
                if (bus.memReady) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end else if (wait_timeout) begin
                    state_next = S_FETCH;
                end
            end
            S_WB, S_BRANCH: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                state_next = S_TRAP;
`else
                state_next = S_FETCH;
`endif
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_FETCH;
            op_reg      <= '0;
            retired_reg <= '0;
            mem_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mem_err_reg <= wait_timeout;
            if (state_reg == S_DECODE) op_reg <= bus.opcode;
            if (retire) retired_reg <= retired_reg + 1'b1;
        end
    end

    // Datapath controls; forced low while reset is held, including the
    // memReady-dependent fetch strobes.
    always_comb begin
        bus.pcWrite     = 1'b0;
        bus.pcWriteCond = 1'b0;
        bus.pcSrc       = 1'b0;
        bus.iorD        = 1'b0;
        bus.irWrite     = 1'b0;
        bus.memRead     = 1'b0;
        bus.memWrite    = 1'b0;
        bus.memtoReg    = 1'b0;
        bus.ALUSrc      = 1'b0;
        bus.ALUOp       = ALUOP_ADD;
        bus.regWrite    = 1'b0;
        bus.branch      = 1'b0;
        if (rst_n) begin
            unique case (state_reg)
                S_FETCH: begin
                    if (req_active) begin
                        bus.memRead = 1'b1;
                        if (bus.memReady) begin
                            bus.irWrite = 1'b1;
                            bus.pcWrite = 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    bus.ALUOp  = (op_reg == OP_RTYPE) ? ALUOP_FUNCT : ALUOP_ADD;
                    bus.ALUSrc = (op_reg != OP_RTYPE);
                end
                S_MEMRD: begin
                    bus.iorD    = 1'b1;
                    bus.memRead = 1'b1;
                    bus.ALUSrc  = 1'b1;
                end
                S_MEMWR: begin
                    bus.iorD     = 1'b1;
                    bus.memWrite = 1'b1;
                    bus.ALUSrc   = 1'b1;
                end
                S_WB: begin
                    bus.regWrite = 1'b1;
                    bus.memtoReg = (op_reg == OP_LOAD);
                end
                S_BRANCH: begin
                    bus.ALUOp       = ALUOP_SUB;
                    bus.branch      = 1'b1;
                    bus.pcWriteCond = 1'b1;
                    bus.pcSrc       = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign memErr       = mem_err_reg;
    assign state        = state_reg;
    assign instrRetired = retired_reg;
`ifdef ILLEGAL_TRAP_EN
    assign illegalInstr = rst_n && (state_reg == S_TRAP);
`endif

endmodule
